// File: rtl/alu_seq_if.sv
// alu_seq_if: handshake and data bundle for the alu_seq sequential ALU.
//   Request side  : in_valid/in_ready handshake with operands bus_a, bus_b and opcode alu_sel.
//   Response side : out_valid/out_ready handshake with alu_out and flags n, z, c, v, dz.
// The master modport is the producer of operations and the consumer of results. The slave
// modport is the ALU.
interface alu_seq_if #(
  parameter int WIDTH     = 8,
  parameter int W_ALU_SEL = 3
);
  logic                        in_valid;
  logic                        in_ready;
  logic signed [WIDTH-1:0]     bus_a;
  logic signed [WIDTH-1:0]     bus_b;
  logic        [W_ALU_SEL-1:0] alu_sel;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [WIDTH-1:0]     alu_out;
  logic                        flag_n;
  logic                        flag_z;
  logic                        flag_c;
  logic                        flag_v;
  logic                        flag_dz;

  modport master (
    output in_valid, bus_a, bus_b, alu_sel, out_ready,
    input  in_ready, out_valid, alu_out, flag_n, flag_z, flag_c, flag_v, flag_dz
  );

  modport slave (
    input  in_valid, bus_a, bus_b, alu_sel, out_ready,
    output in_ready, out_valid, alu_out, flag_n, flag_z, flag_c, flag_v, flag_dz
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: sequential signed ALU with valid/ready handshakes on both sides.
//   clk  : rising-edge clock
//   rstn : asynchronous active-low reset
//   bus  : alu_seq_if slave
//          - in_valid/in_ready, bus_a, bus_b, alu_sel : operation request
//          - out_valid/out_ready, alu_out, flag_n/z/c/v/dz : registered result
// Every opcode except divide completes on the accepting edge. Divide runs a restoring
// divider on the operand magnitudes for WIDTH cycles. A held result can drain in the same
// cycle that a new operation is accepted, which gives one result per cycle.
module alu_seq #(
  parameter int WIDTH     = 8,
  parameter int W_ALU_SEL = 3
) (
  input logic      clk,
  input logic      rstn,
  alu_seq_if.slave bus
);

  localparam int CntW = $clog2(WIDTH);
  localparam int Msb  = WIDTH - 1;

  localparam logic [W_ALU_SEL-1:0] OpPass = W_ALU_SEL'(0);
  localparam logic [W_ALU_SEL-1:0] OpAdd  = W_ALU_SEL'(1);
  localparam logic [W_ALU_SEL-1:0] OpSub  = W_ALU_SEL'(2);
  localparam logic [W_ALU_SEL-1:0] OpMul  = W_ALU_SEL'(3);
  localparam logic [W_ALU_SEL-1:0] OpHalf = W_ALU_SEL'(4);
  localparam logic [W_ALU_SEL-1:0] OpDiv  = W_ALU_SEL'(5);
  localparam logic [W_ALU_SEL-1:0] OpAnd  = W_ALU_SEL'(6);
  localparam logic [W_ALU_SEL-1:0] OpXor  = W_ALU_SEL'(7);

  typedef enum logic [1:0] {StIdle, StDiv, StHold} state_e;

  state_e           state_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] res_q;
  logic             n_q, z_q, c_q, v_q, dz_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic             neg_q;
  logic [CntW-1:0]  cnt_q;

  logic [WIDTH-1:0]     a, b;
  logic [W_ALU_SEL-1:0] sel;
  logic                 in_ready, accept;

  assign a   = bus.bus_a;
  assign b   = bus.bus_b;
  assign sel = bus.alu_sel;

  // Gated with rstn so that in_ready reads 0 while reset is held.
  assign in_ready = rstn & ((state_q == StIdle) | ((state_q == StHold) & bus.out_ready));
  assign accept   = bus.in_valid & in_ready;

  // Single-cycle datapath.
  logic [WIDTH:0]          sum, diff;
  logic [2*WIDTH-1:0]      a_ext, b_ext, prod;
  logic signed [WIDTH-1:0] half_t;
  logic [WIDTH-1:0]        sc_res;
  logic                    sc_c, sc_v;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};  // bit WIDTH is the unsigned borrow
    a_ext  = {{WIDTH{a[Msb]}}, a};
    b_ext  = {{WIDTH{b[Msb]}}, b};
    prod   = a_ext * b_ext;
    // Adding 1 to negative values before the arithmetic shift truncates toward zero.
    half_t = a + {{(WIDTH-1){1'b0}}, a[Msb]};
    sc_res = a;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (sel)
      OpAdd: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (a[Msb] == b[Msb]) && (sum[Msb] != a[Msb]);
      end
      OpSub: begin
        sc_res = diff[WIDTH-1:0];
        sc_c   = diff[WIDTH];
        sc_v   = (a[Msb] != b[Msb]) && (diff[Msb] != a[Msb]);
      end
      OpMul: begin
        sc_res = prod[WIDTH-1:0];
        sc_v   = prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[Msb]}};
      end
      OpHalf:  sc_res = half_t >>> 1;
      OpAnd:   sc_res = a & b;
      OpXor:   sc_res = a ^ b;
      OpPass:  sc_res = a;
      default: sc_res = a;
    endcase
  end

  // Divider: magnitudes at launch, one restoring step per cycle.
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, trial;
  logic             ge;
  logic [WIDTH-1:0] rem_d, quo_d, div_res;
  logic             div_zero, div_v;

  always_comb begin
    a_mag    = a[Msb] ? ('0 - a) : a;
    b_mag    = b[Msb] ? ('0 - b) : b;
    shifted  = {rem_q, quo_q[Msb]};
    trial    = shifted - {1'b0, dvs_q};
    ge       = ~trial[WIDTH];
    rem_d    = ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_d    = {quo_q[WIDTH-2:0], ge};
    div_zero = (dvs_q == '0);
    // A positive quotient with the MSB set can only be MIN / -1.
    div_v    = ~div_zero & ~neg_q & quo_d[Msb];
    if (div_zero) begin
      div_res = '1;
    end else begin
      div_res = neg_q ? ('0 - quo_d) : quo_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      n_q         <= 1'b0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      dz_q        <= 1'b0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      neg_q       <= 1'b0;
      cnt_q       <= '0;
    end else if (accept) begin
      if (sel == OpDiv) begin
        state_q     <= StDiv;
        out_valid_q <= 1'b0;
        rem_q       <= '0;
        quo_q       <= a_mag;
        dvs_q       <= b_mag;
        neg_q       <= a[Msb] ^ b[Msb];
        cnt_q       <= '0;
      end else begin
        state_q     <= StHold;
        out_valid_q <= 1'b1;
        res_q       <= sc_res;
        n_q         <= sc_res[Msb];
        z_q         <= (sc_res == '0);
        c_q         <= sc_c;
        v_q         <= sc_v;
        dz_q        <= 1'b0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
        end
        StDiv: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 1'b1;
          // The last quotient bit and the sign fix share one edge.
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state_q     <= StHold;
            out_valid_q <= 1'b1;
            res_q       <= div_res;
            n_q         <= div_res[Msb];
            z_q         <= (div_res == '0);
            c_q         <= 1'b0;
            v_q         <= div_v;
            dz_q        <= div_zero;
          end
        end
        StHold: begin
          if (bus.out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.alu_out   = res_q;
  assign bus.flag_n    = n_q;
  assign bus.flag_z    = z_q;
  assign bus.flag_c    = c_q;
  assign bus.flag_v    = v_q;
  assign bus.flag_dz   = dz_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (WIDTH = 8).
// Accepted operations push an integer-arithmetic model result into a queue. A monitor pops
// and compares on every out_valid & out_ready.
module tb_alu_seq;
  localparam int W = 8;
  localparam longint MaxS = (longint'(1) <<< (W - 1)) - 1;
  localparam longint MinS = -(longint'(1) <<< (W - 1));
  localparam longint MaxU = (longint'(1) <<< W) - 1;

  typedef struct packed {
    logic [W-1:0] res;
    logic         n, z, c, v, dz;
  } exp_t;

  logic clk;
  logic rstn;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_pops   = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  alu_seq_if #(.WIDTH(W), .W_ALU_SEL(3)) ifc ();

  alu_seq #(.WIDTH(W), .W_ALU_SEL(3)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Model built from the operation rules with plain integer arithmetic.
  function automatic exp_t ref_model(input logic [2:0] op, input logic [W-1:0] a, b);
    longint ai, bi, au, bu, r;
    exp_t   e;
    ai = longint'($signed(a));
    bi = longint'($signed(b));
    au = longint'(a);
    bu = longint'(b);
    e  = '0;
    r  = 0;
    case (op)
      3'd0: r = ai;
      3'd1: begin r = ai + bi; e.c = (au + bu) > MaxU; e.v = (r > MaxS) || (r < MinS); end
      3'd2: begin r = ai - bi; e.c = au < bu;          e.v = (r > MaxS) || (r < MinS); end
      3'd3: begin r = ai * bi; e.v = (r > MaxS) || (r < MinS); end
      3'd4: r = ai / 2;
      3'd5: begin
        if (bi == 0) begin r = -1; e.dz = 1'b1; end
        else begin r = ai / bi; e.v = r > MaxS; end
      end
      3'd6: r = au & bu;
      default: r = au ^ bu;
    endcase
    e.res = r[W-1:0];
    e.n   = e.res[W-1];
    e.z   = (e.res == '0);
    return e;
  endfunction

  function automatic exp_t dut_out();
    return {ifc.alu_out, ifc.flag_n, ifc.flag_z, ifc.flag_c, ifc.flag_v, ifc.flag_dz};
  endfunction

  // Monitor: one comparison per delivered result.
  always @(negedge clk) begin
    if (rstn && ifc.out_valid && ifc.out_ready) begin
      n_pops++;
      if (exp_q.size() == 0) begin
        chk("spurious_result", ifc.out_valid, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result", dut_out(), mon_e);
      end
    end
  end

  // Call just after a rising edge. Returns just after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, b, output int waited);
    ifc.alu_sel  = op;
    ifc.bus_a    = a;
    ifc.bus_b    = b;
    ifc.in_valid = 1'b1;
    waited       = 0;
    @(negedge clk);
    while (!ifc.in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (ifc.in_ready) exp_q.push_back(ref_model(op, a, b));
    else chk("accept_timeout", ifc.in_ready, 1'b1);
    @(posedge clk);
    #1;
    // Scramble the inputs to show they are not sampled after acceptance.
    ifc.in_valid = 1'b0;
    ifc.alu_sel  = 3'($urandom);
    ifc.bus_a    = W'($urandom);
    ifc.bus_b    = W'($urandom);
  endtask

  task automatic wait_valid(output int lat, output int ready_high);
    lat        = 0;
    ready_high = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!ifc.out_valid && ifc.in_ready) ready_high++;
    end while (!ifc.out_valid && lat < 64);
  endtask

  task automatic run_one(input string name, input logic [2:0] op, input logic [W-1:0] a, b,
                         input int exp_lat, input logic [W-1:0] exp_res,
                         input logic [4:0] exp_flags);
    int w, lat, rh;
    @(posedge clk);
    #1;
    issue(op, a, b, w);
    wait_valid(lat, rh);
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_busy_in_ready"}, rh, 0);
    chk({name, "_out"}, dut_out(), {exp_res, exp_flags});
  endtask

  initial begin
    int   w, lat, rh, sent, base;
    logic accepted;
    logic [2:0] op;

    rstn          = 1'b1;
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    ifc.bus_a     = '0;
    ifc.bus_b     = '0;
    ifc.alu_sel   = '0;
    #2 rstn = 1'b0;
    #1 chk("reset_outputs", {ifc.out_valid, ifc.in_ready, dut_out()}, '0);
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    #1 chk("ready_after_reset", {ifc.out_valid, ifc.in_ready}, 2'b01);

    // Directed operations. Flags are {n, z, c, v, dz}.
    run_one("add_100_50",  3'd1, 8'd100, 8'd50,  1, 8'h96, 5'b10010);
    run_one("sub_5_7",     3'd2, 8'd5,   8'd7,   1, 8'hFE, 5'b10100);
    run_one("half_m7",     3'd4, 8'hF9,  8'h00,  1, 8'hFD, 5'b10000);
    run_one("div_m7_2",    3'd5, 8'hF9,  8'd2,   9, 8'hFD, 5'b10000);
    run_one("div_min_m1",  3'd5, 8'h80,  8'hFF,  9, 8'h80, 5'b10010);
    run_one("div_by_zero", 3'd5, 8'd37,  8'd0,   9, 8'hFF, 5'b10001);
    run_one("div_100_7",   3'd5, 8'd100, 8'd7,   9, 8'h0E, 5'b00000);
    run_one("mul_16_16",   3'd3, 8'd16,  8'd16,  1, 8'h00, 5'b01010);
    run_one("xor_same",    3'd7, 8'hA5,  8'hA5,  1, 8'h00, 5'b01000);

    // Held result under backpressure.
    @(posedge clk);
    #1 ifc.out_ready = 1'b0;
    issue(3'd3, 8'hF6, 8'd13, w);  // -10 * 13 = -130, low byte 0x7E, overflows
    repeat (5) begin
      @(negedge clk);
      chk("hold_stable", {ifc.out_valid, ifc.in_ready, dut_out()}, {2'b10, 8'h7E, 5'b00010});
    end
    @(posedge clk);
    #1 ifc.out_ready = 1'b1;
    base = n_pops;
    for (int i = 0; i < 20; i++) begin
      op = 3'($urandom_range(7));
      if (op == 3'd5) op = 3'd4;
      issue(op, W'($urandom), W'($urandom), w);
      chk("stream_no_stall", w, 0);
    end
    repeat (2) @(negedge clk);
    chk("stream_pop_count", n_pops - base, 21);

    // Randomized traffic with random backpressure.
    accepted = 1'b0;
    sent     = 0;
    for (int k = 0; k < 1500 && sent < 150; k++) begin
      @(posedge clk);
      #1;
      if (accepted) ifc.in_valid = 1'b0;
      ifc.out_ready = ($urandom_range(3) != 0);
      if (!ifc.in_valid) begin
        ifc.alu_sel = 3'($urandom);
        ifc.bus_a   = ($urandom_range(9) == 0) ? 8'h80 : W'($urandom);
        ifc.bus_b   = ($urandom_range(7) == 0) ? 8'h00 : W'($urandom);
        if ($urandom_range(2) != 0) ifc.in_valid = 1'b1;
      end
      @(negedge clk);
      accepted = ifc.in_valid && ifc.in_ready;
      if (accepted) begin
        exp_q.push_back(ref_model(ifc.alu_sel, ifc.bus_a, ifc.bus_b));
        sent++;
      end
    end
    @(posedge clk);
    #1;
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    chk("rand_ops_sent", sent, 150);
    chk("rand_drained", exp_q.size(), 0);

    // Reset in the middle of a divide.
    @(posedge clk);
    #1;
    issue(3'd5, 8'd99, 8'd5, w);
    repeat (3) @(negedge clk);
    #2 rstn = 1'b0;
    #1 chk("reset_mid_div", {ifc.out_valid, ifc.in_ready, dut_out()}, '0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    #1 chk("ready_after_release", {ifc.out_valid, ifc.in_ready}, 2'b01);
    issue(3'd6, 8'h3C, 8'h0F, w);
    chk("accept_after_release", w, 0);
    wait_valid(lat, rh);
    chk("post_reset_latency", lat, 1);
    chk("post_reset_out", dut_out(), {8'h0C, 5'b00000});
    repeat (2) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
